// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg
//   Shared types for the front-end memory pipe:
//     bp_fe_mem_op_e        - command opcode carried in the MSB of cmd_i
//     bp_fe_mem_pipe_resp_s - fetch response (status flags plus fetched data)
//     privilege encodings used by the page-permission check
//   The response data field is sized for the default fetch of
//   2 x 32-bit instructions. Narrower fetch widths are zero-extended into it.
package bp_fe_pkg;

  typedef enum logic {
    e_fe_op_fetch = 1'b0,
    e_fe_op_fence = 1'b1
  } bp_fe_mem_op_e;

  localparam int bp_fe_data_width_gp = 64;

  localparam logic [1:0] bp_priv_user_gp  = 2'd0;
  localparam logic [1:0] bp_priv_super_gp = 2'd1;
  localparam logic [1:0] bp_priv_mach_gp  = 2'd3;

  typedef struct packed {
    logic                           misaligned;
    logic                           access_fault;
    logic                           page_fault;
    logic                           itlb_miss;
    logic                           icache_miss;
    logic [bp_fe_data_width_gp-1:0] data;
  } bp_fe_mem_pipe_resp_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small
//   Small circular-buffer FIFO with one write port and one read port.
//   Ports:
//     i_clk, i_reset_n  - clock, synchronous active-low reset
//     i_v, i_data       - push request and data (ignored while full)
//     o_ready           - space available
//     o_v, o_data       - head entry valid and data (registered storage, no bypass)
//     i_yumi            - head consumed this cycle
//     o_count           - number of entries held
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_v,
  output logic                       o_ready,
  input  logic [width_p-1:0]         i_data,
  output logic                       o_v,
  output logic [width_p-1:0]         o_data,
  input  logic                       i_yumi,
  output logic [$clog2(els_p+1)-1:0] o_count
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w-1:0]   r_rptr;
  logic [ptr_w-1:0]   r_wptr;
  logic [cnt_w-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == cnt_w'(els_p));
  assign w_empty = (r_count == '0);
  assign w_push  = i_v & ~w_full;
  assign w_pop   = i_yumi & ~w_empty;

  assign o_ready = ~w_full;
  assign o_v     = ~w_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_mem_pipe.sv
// bp_fe_mem_pipe
//   Three-stage instruction fetch pipe between the front end and the
//   I-TLB / I-cache, with a credited response buffer.
//     S0  accept command, issue TLB lookup and I-cache access (combinational)
//     S1  TLB result returns; access and page permission checks
//     S2  I-cache data returns; response is pushed into the buffer
//   A fetch accepted in cycle t is pushed at t+2 and first seen on resp_o at t+3.
//   Ports:
//     clk_i, reset_n_i                    - clock, synchronous active-low reset
//     cmd_i, cmd_v_i, cmd_yumi_o          - {op, vaddr} command, valid, consumed
//     priv_i, translation_en_i, poison_i  - privilege, translation on, kill S1/S2
//     tlb_v_o, tlb_flush_o, tlb_vtag_o    - TLB lookup, flush (on fence), lookup tag
//     tlb_v_i, tlb_miss_i, tlb_entry_i    - TLB result {ptag, u, x}, one cycle later
//     icache_v_o, icache_ready_i          - I-cache issue / accept
//     icache_data_v_i, icache_data_i      - I-cache hit data, two cycles after issue
//     resp_o, resp_v_o, resp_ready_i      - response, valid/ready
//   Build option:
//     BP_FE_MEM_PIPE_ALIGN_CHECK_EN - flag fetches with vaddr[1:0] != 0 as
//     misaligned; they skip the TLB and cache but still return a response.
module bp_fe_mem_pipe
  import bp_fe_pkg::*;
#(
  parameter int                    vaddr_width_p    = 39,
  parameter int                    ptag_width_p     = 28,
  parameter int                    instr_width_p    = 32,
  parameter int                    fetch_width_p    = 2,
  parameter int                    resp_els_p       = 4,
  parameter logic [ptag_width_p-1:0] dram_base_ptag_p = 'h80000
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,

  input  logic [vaddr_width_p:0]                  cmd_i,
  input  logic                                    cmd_v_i,
  output logic                                    cmd_yumi_o,

  input  logic [1:0]                              priv_i,
  input  logic                                    translation_en_i,
  input  logic                                    poison_i,

  output logic                                    tlb_v_o,
  output logic                                    tlb_flush_o,
  output logic [vaddr_width_p-13:0]               tlb_vtag_o,

  input  logic                                    tlb_v_i,
  input  logic                                    tlb_miss_i,
  input  logic [ptag_width_p+1:0]                 tlb_entry_i,

  output logic                                    icache_v_o,
  input  logic                                    icache_ready_i,

  input  logic                                    icache_data_v_i,
  input  logic [fetch_width_p*instr_width_p-1:0]  icache_data_i,

  output bp_fe_mem_pipe_resp_s                    resp_o,
  output logic                                    resp_v_o,
  input  logic                                    resp_ready_i
);

  localparam int cnt_w  = $clog2(resp_els_p + 1);
  localparam int resp_w = $bits(bp_fe_mem_pipe_resp_s);

  // S0 ------------------------------------------------------------------
  bp_fe_mem_op_e              w_op;
  logic [vaddr_width_p-1:0]   w_vaddr;
  logic                       w_s0_mis;
  logic [cnt_w:0]             w_used;
  logic                       w_credit_ok;
  logic                       w_fetch_yumi;
  logic                       w_fence_yumi;
  logic [cnt_w-1:0]           w_fifo_count;

  // S1 / S2 state
  logic r_s1_v;
  logic r_s1_mis;
  logic r_s2_v;
  logic r_s2_mis;
  logic r_s2_access;
  logic r_s2_page;
  logic r_s2_itlb;

  assign w_op    = bp_fe_mem_op_e'(cmd_i[vaddr_width_p]);
  assign w_vaddr = cmd_i[vaddr_width_p-1:0];

`ifdef BP_FE_MEM_PIPE_ALIGN_CHECK_EN
  assign w_s0_mis = |w_vaddr[1:0];
`else
  assign w_s0_mis = 1'b0;
`endif

  // Everything that may still land in the buffer holds a credit, so the
  // buffer can never overflow and never sees push+pop while full.
  assign w_used = {1'b0, w_fifo_count}
                + {{cnt_w{1'b0}}, r_s1_v}
                + {{cnt_w{1'b0}}, r_s2_v};
  assign w_credit_ok = (w_used < (cnt_w+1)'(resp_els_p));

  assign w_fetch_yumi = reset_n_i & cmd_v_i & (w_op == e_fe_op_fetch)
                      & icache_ready_i & w_credit_ok;
  // A fence flushes the TLB, so it must not overtake a lookup still in S1/S2.
  assign w_fence_yumi = reset_n_i & cmd_v_i & (w_op == e_fe_op_fence)
                      & ~r_s1_v & ~r_s2_v;

  assign cmd_yumi_o  = w_fetch_yumi | w_fence_yumi;
  assign tlb_flush_o = w_fence_yumi;
  assign tlb_v_o     = w_fetch_yumi & ~w_s0_mis;
  assign icache_v_o  = w_fetch_yumi & ~w_s0_mis;
  assign tlb_vtag_o  = w_vaddr[vaddr_width_p-1:12];

  // S1 ------------------------------------------------------------------
  logic [ptag_width_p-1:0] w_s1_ptag;
  logic                    w_s1_u;
  logic                    w_s1_x;
  logic                    w_s1_xlate_ok;
  logic                    w_s1_itlb_miss;
  logic                    w_s1_access;
  logic                    w_s1_page;
  logic                    w_s1_priv_s;
  logic                    w_s1_priv_u;

  assign w_s1_ptag = tlb_entry_i[ptag_width_p+1:2];
  assign w_s1_u    = tlb_entry_i[1];
  assign w_s1_x    = tlb_entry_i[0];

  // Permission checks only mean something when a translation came back.
  assign w_s1_xlate_ok  = ~r_s1_mis & tlb_v_i & ~tlb_miss_i;
  assign w_s1_itlb_miss = ~r_s1_mis & tlb_v_i &  tlb_miss_i;

  assign w_s1_access = w_s1_xlate_ok
                     & ((w_s1_ptag < dram_base_ptag_p)
                        | (|w_s1_ptag[ptag_width_p-1 -: 4]));

  assign w_s1_priv_s = (priv_i == bp_priv_super_gp);
  assign w_s1_priv_u = (priv_i == bp_priv_user_gp);
  assign w_s1_page   = w_s1_xlate_ok & translation_en_i
                     & (~w_s1_x | (w_s1_priv_s & w_s1_u) | (w_s1_priv_u & ~w_s1_u));

  // S2 ------------------------------------------------------------------
  bp_fe_mem_pipe_resp_s w_s2_resp;
  logic                 w_s2_any;
  logic                 w_push;

  always_comb begin
    w_s2_resp              = '0;
    w_s2_resp.misaligned   = r_s2_mis;
    w_s2_resp.access_fault = r_s2_access;
    w_s2_resp.page_fault   = r_s2_page;
    w_s2_resp.itlb_miss    = r_s2_itlb;
    w_s2_resp.icache_miss  = ~icache_data_v_i;
    w_s2_any = w_s2_resp.misaligned | w_s2_resp.access_fault | w_s2_resp.page_fault
             | w_s2_resp.itlb_miss  | w_s2_resp.icache_miss;
    // Data is only handed out for a clean translated hit.
    w_s2_resp.data = w_s2_any ? '0 : bp_fe_data_width_gp'(icache_data_i);
  end

  assign w_push = r_s2_v & ~poison_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_s1_v      <= 1'b0;
      r_s1_mis    <= 1'b0;
      r_s2_v      <= 1'b0;
      r_s2_mis    <= 1'b0;
      r_s2_access <= 1'b0;
      r_s2_page   <= 1'b0;
      r_s2_itlb   <= 1'b0;
    end else begin
      // Poison kills S1/S2 but not the command accepted in the same cycle.
      r_s1_v      <= w_fetch_yumi;
      r_s1_mis    <= w_s0_mis;
      r_s2_v      <= r_s1_v & ~poison_i;
      r_s2_mis    <= r_s1_mis;
      r_s2_access <= w_s1_access;
      r_s2_page   <= w_s1_page;
      r_s2_itlb   <= w_s1_itlb_miss;
    end
  end

  // Response buffer ------------------------------------------------------
  logic              w_fifo_ready;
  logic              w_fifo_v;
  logic [resp_w-1:0] w_fifo_data;

  bsg_fifo_1r1w_small #(
    .width_p (resp_w),
    .els_p   (resp_els_p)
  ) u_resp_fifo (
    .i_clk     (clk_i),
    .i_reset_n (reset_n_i),
    .i_v       (w_push),
    .o_ready   (w_fifo_ready),
    .i_data    (w_s2_resp),
    .o_v       (w_fifo_v),
    .o_data    (w_fifo_data),
    .i_yumi    (resp_v_o & resp_ready_i),
    .o_count   (w_fifo_count)
  );

  assign resp_v_o = reset_n_i & w_fifo_v;
  assign resp_o   = w_fifo_data;

  // Page-offset bits are not needed past S0; fifo ready is implied by credits.
  logic w_unused;
  assign w_unused = ^{w_vaddr[11:0], w_fifo_ready};

endmodule

// File: tb/tb_bp_fe_mem_pipe.sv
module tb_bp_fe_mem_pipe;
  import bp_fe_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic [39:0]          cmd_i;
  logic                 cmd_v_i;
  logic                 cmd_yumi_o;
  logic [1:0]           priv_i;
  logic                 translation_en_i;
  logic                 poison_i;
  logic                 tlb_v_o;
  logic                 tlb_flush_o;
  logic [26:0]          tlb_vtag_o;
  logic                 tlb_v_i = 1'b0;
  logic                 tlb_miss_i = 1'b0;
  logic [29:0]          tlb_entry_i = '0;
  logic                 icache_v_o;
  logic                 icache_ready_i;
  logic                 icache_data_v_i = 1'b0;
  logic [63:0]          icache_data_i = '0;
  bp_fe_mem_pipe_resp_s resp_o;
  logic                 resp_v_o;
  logic                 resp_ready_i;

  bp_fe_mem_pipe dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .cmd_i            (cmd_i),
    .cmd_v_i          (cmd_v_i),
    .cmd_yumi_o       (cmd_yumi_o),
    .priv_i           (priv_i),
    .translation_en_i (translation_en_i),
    .poison_i         (poison_i),
    .tlb_v_o          (tlb_v_o),
    .tlb_flush_o      (tlb_flush_o),
    .tlb_vtag_o       (tlb_vtag_o),
    .tlb_v_i          (tlb_v_i),
    .tlb_miss_i       (tlb_miss_i),
    .tlb_entry_i      (tlb_entry_i),
    .icache_v_o       (icache_v_o),
    .icache_ready_i   (icache_ready_i),
    .icache_data_v_i  (icache_data_v_i),
    .icache_data_i    (icache_data_i),
    .resp_o           (resp_o),
    .resp_v_o         (resp_v_o),
    .resp_ready_i     (resp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [38:0] vaddr;
    logic [27:0] ptag;
    logic        u;
    logic        x;
    logic        miss;
    logic        hit;
    logic [63:0] data;
    bit          want_resp;
  } desc_t;

  int n_cmp = 0;
  int n_mis = 0;
  int n_resp = 0;
  int cyc = 0;
  int acc_cyc = 0;

  bp_fe_mem_pipe_resp_s sb_q[$];
  desc_t cur;
  desc_t s_d;
  desc_t r2_d;
  logic  s_tlb = 1'b0;
  logic  s_ic  = 1'b0;
  logic  r2_ic = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic desc_t mk(input logic [38:0] va, input logic [27:0] pt, input logic u,
                               input logic x, input logic miss, input logic hit,
                               input logic [63:0] data);
    desc_t d;
    d.vaddr = va; d.ptag = pt; d.u = u; d.x = x; d.miss = miss; d.hit = hit;
    d.data = data; d.want_resp = 1'b1;
    return d;
  endfunction

  function automatic bp_fe_mem_pipe_resp_s model(input desc_t d, input logic [1:0] pv,
                                                 input logic te);
    bp_fe_mem_pipe_resp_s r;
    r = '0;
`ifdef BP_FE_MEM_PIPE_ALIGN_CHECK_EN
    if (d.vaddr[1:0] != 2'b00) begin
      r.misaligned  = 1'b1;
      r.icache_miss = 1'b1;
      return r;
    end
`endif
    if (d.miss) begin
      r.itlb_miss = 1'b1;
    end else begin
      r.access_fault = (d.ptag < 28'h80000) || (d.ptag[27:24] != 4'h0);
      r.page_fault   = te && (!d.x || (pv == bp_priv_super_gp && d.u)
                                   || (pv == bp_priv_user_gp && !d.u));
    end
    r.icache_miss = !d.hit;
    if (!(r.access_fault || r.page_fault || r.itlb_miss || r.icache_miss))
      r.data = d.data;
    return r;
  endfunction

  // Acceptance monitor / scoreboard push, and response checker.
  always @(negedge clk_i) begin
    bp_fe_mem_pipe_resp_s e;
    s_tlb = tlb_v_o;
    s_ic  = icache_v_o;
    s_d   = cur;
    if (cmd_yumi_o && !cmd_i[39]) begin
      acc_cyc = cyc;
      chk("vtag", tlb_vtag_o, cur.vaddr[38:12]);
      if (cur.want_resp) sb_q.push_back(model(cur, priv_i, translation_en_i));
    end
    if (resp_v_o && resp_ready_i) begin
      n_resp++;
      chk("resp_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("resp", resp_o, e);
      end
    end
  end

  // TLB answers one cycle after lookup, I-cache two cycles after issue.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    tlb_v_i         = s_tlb;
    tlb_miss_i      = s_tlb & s_d.miss;
    tlb_entry_i     = {s_d.ptag, s_d.u, s_d.x};
    icache_data_v_i = r2_ic & r2_d.hit;
    icache_data_i   = r2_d.data;
    r2_ic = s_ic;
    r2_d  = s_d;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input desc_t d);
    bit ok;
    ok = 1'b0;
    cur = d;
    cmd_i = {1'b0, d.vaddr};
    cmd_v_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (cmd_yumi_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("accept", ok, 1'b1);
    tick();
    cmd_v_i = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) tick();
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    desc_t d;
    desc_t bp[6];
    int    idx;
    int    base;

    reset_n_i = 1'b0;
    cmd_i = {1'b0, 39'h80000000};
    cmd_v_i = 1'b1;
    priv_i = bp_priv_super_gp;
    translation_en_i = 1'b1;
    poison_i = 1'b0;
    icache_ready_i = 1'b1;
    resp_ready_i = 1'b1;
    cur = mk(39'h0, 28'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    cur.want_resp = 1'b0;
    repeat (3) tick();
    @(negedge clk_i);
    chk("rst_cmd_yumi", cmd_yumi_o, 1'b0);
    chk("rst_tlb_v", tlb_v_o, 1'b0);
    chk("rst_tlb_flush", tlb_flush_o, 1'b0);
    chk("rst_icache_v", icache_v_o, 1'b0);
    chk("rst_resp_v", resp_v_o, 1'b0);
    tick();
    cmd_v_i = 1'b0;
    reset_n_i = 1'b1;
    repeat (2) tick();

    // Clean hit and latency.
    send(mk(39'h80000000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (resp_v_o) break;
    end
    chk("latency", cyc - acc_cyc, 3);
    tick();
    drain(10);

    // Access faults and the DRAM base boundary.
    send(mk(39'h80001000, 28'h00010, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1111));
    send(mk(39'h80002000, 28'h7FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 64'h2222));
    send(mk(39'h80003000, 28'h1080000, 1'b0, 1'b1, 1'b0, 1'b1, 64'h3333));
    send(mk(39'h80004000, 28'h80001, 1'b0, 1'b1, 1'b0, 1'b1, 64'h4444));
    drain(10);

    // Page permission checks.
    priv_i = bp_priv_user_gp;
    send(mk(39'h80005000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'h5555));
    send(mk(39'h80006000, 28'h80000, 1'b1, 1'b1, 1'b0, 1'b1, 64'h6666));
    drain(10);
    priv_i = bp_priv_super_gp;
    send(mk(39'h80007000, 28'h80000, 1'b1, 1'b1, 1'b0, 1'b1, 64'h7777));
    send(mk(39'h80008000, 28'h80000, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8888));
    drain(10);
    priv_i = bp_priv_user_gp;
    translation_en_i = 1'b0;
    send(mk(39'h80009000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'h9999));
    drain(10);
    priv_i = bp_priv_super_gp;
    translation_en_i = 1'b1;

    // TLB miss and cache miss.
    send(mk(39'h8000A000, 28'h80000, 1'b0, 1'b1, 1'b1, 1'b1, 64'hAAAA));
    send(mk(39'h8000B000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b0, 64'hBBBB));
    drain(10);

    // Cache not ready blocks a fetch.
    icache_ready_i = 1'b0;
    cur = mk(39'h8000C000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hCCCC);
    cmd_i = {1'b0, cur.vaddr};
    cmd_v_i = 1'b1;
    @(negedge clk_i);
    chk("icache_busy_yumi", cmd_yumi_o, 1'b0);
    tick();
    icache_ready_i = 1'b1;
    cmd_v_i = 1'b0;

    // Fence on empty pipe, then fence held off by a fetch in flight.
    cmd_i = {1'b1, 39'h0};
    cmd_v_i = 1'b1;
    @(negedge clk_i);
    chk("fence_yumi", cmd_yumi_o, 1'b1);
    chk("fence_flush", tlb_flush_o, 1'b1);
    chk("fence_no_icache", icache_v_o, 1'b0);
    tick();
    cmd_v_i = 1'b0;
    send(mk(39'h8000D000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hDDDD));
    cmd_i = {1'b1, 39'h0};
    cmd_v_i = 1'b1;
    @(negedge clk_i);
    chk("fence_blk_s1", cmd_yumi_o, 1'b0);
    chk("fence_blk_flush", tlb_flush_o, 1'b0);
    tick();
    @(negedge clk_i);
    chk("fence_blk_s2", cmd_yumi_o, 1'b0);
    tick();
    @(negedge clk_i);
    chk("fence_go", tlb_flush_o, 1'b1);
    tick();
    cmd_v_i = 1'b0;
    drain(10);

    // Misaligned fetch.
    send(mk(39'h80000002, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF));
`ifdef BP_FE_MEM_PIPE_ALIGN_CHECK_EN
    chk("mis_icache_v", s_ic, 1'b0);
    chk("mis_tlb_v", s_tlb, 1'b0);
`else
    chk("mis_icache_v", s_ic, 1'b1);
    chk("mis_tlb_v", s_tlb, 1'b1);
`endif
    drain(10);

    // Back-pressure: credits cap acceptance at the buffer depth.
    for (int k = 0; k < 6; k++)
      bp[k] = mk(39'h80010000 + 39'(k * 8), 28'h80000 + 28'(k), 1'b0, 1'b1, 1'b0, 1'b1,
                 {32'hB0B00000 + 32'(k), 32'h5A5A0000 + 32'(k)});
    resp_ready_i = 1'b0;
    base = n_resp;
    idx = 0;
    cur = bp[0];
    cmd_i = {1'b0, bp[0].vaddr};
    cmd_v_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (cmd_yumi_o) idx++;
      tick();
      if (idx < 6) begin
        cur = bp[idx];
        cmd_i = {1'b0, bp[idx].vaddr};
      end else begin
        cmd_v_i = 1'b0;
      end
    end
    @(negedge clk_i);
    chk("bp_accepted", idx, 4);
    chk("bp_yumi_low", cmd_yumi_o, 1'b0);
    chk("bp_resp_v", resp_v_o, 1'b1);
    chk("bp_held", n_resp - base, 0);
    tick();
    resp_ready_i = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      @(negedge clk_i);
      if (cmd_yumi_o) idx++;
      tick();
      if (idx < 6) begin
        cur = bp[idx];
        cmd_i = {1'b0, bp[idx].vaddr};
      end else begin
        cmd_v_i = 1'b0;
      end
    end
    cmd_v_i = 1'b0;
    chk("bp_all_accepted", idx, 6);
    drain(20);
    chk("bp_resp_count", n_resp - base, 6);

    // Poison two in-flight fetches with the buffer holding two more.
    resp_ready_i = 1'b0;
    base = n_resp;
    send(mk(39'h80020000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hA0A0));
    send(mk(39'h80020008, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hA1A1));
    repeat (3) tick();
    d = mk(39'h80020010, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hC0C0);
    d.want_resp = 1'b0;
    send(d);
    d = mk(39'h80020018, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hC1C1);
    d.want_resp = 1'b0;
    send(d);
    poison_i = 1'b1;
    cur = mk(39'h80020020, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hE0E0);
    cmd_i = {1'b0, cur.vaddr};
    cmd_v_i = 1'b1;
    @(negedge clk_i);
    chk("poison_no_credit", cmd_yumi_o, 1'b0);
    tick();
    poison_i = 1'b0;
    @(negedge clk_i);
    chk("poison_credit_back", cmd_yumi_o, 1'b1);
    tick();
    cmd_v_i = 1'b0;
    resp_ready_i = 1'b1;
    drain(20);
    repeat (4) tick();
    chk("poison_resp_count", n_resp - base, 3);

    // Reset in the middle of traffic drops everything.
    resp_ready_i = 1'b0;
    send(mk(39'h80030000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hF0F0));
    send(mk(39'h80030008, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hF1F1));
    send(mk(39'h80030010, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hF2F2));
    tick();
    reset_n_i = 1'b0;
    sb_q.delete();
    base = n_resp;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_resp_v", resp_v_o, 1'b0);
    repeat (2) tick();
    reset_n_i = 1'b1;
    repeat (8) tick();
    chk("rst_mid_no_resp", n_resp - base, 0);
    send(mk(39'h80040000, 28'h80000, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1234_5678));
    drain(10);
    chk("rst_mid_after", n_resp - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
